reg_access_ctrl: RTL and testbench

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

---
 rtl/reg_access_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_reg_access_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: operand fetch stage for an LC2K pipeline.
// Accepts an instruction, reads its two source registers (with
// writeback forwarding), holds the operand bundle until the
// consumer takes it, and tracks pending destination registers in
// a scoreboard so that dependent instructions stall at issue.
//
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   in_valid/in_ready/in_instr - instruction handshake
//   read_regA/read_regB       - register-file read addresses
//   aluValA/regBvalue         - register-file read data (same cycle)
//   write_reg/write_value     - register-file write port
//   CONTROL_ENABLE_REG_WRITE  - register-file write strobe
//   wb_valid/wb_reg/wb_value  - writeback request (always accepted)
//   out_valid/out_ready       - operand bundle handshake
//   out_instr/out_opA/out_opB - operand bundle
//   wb_err                    - writeback to a non-pending register
module reg_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [2:0]  read_regA,
  output logic [2:0]  read_regB,
  input  logic [31:0] aluValA,
  input  logic [31:0] regBvalue,
  output logic [2:0]  write_reg,
  output logic [31:0] write_value,
  output logic        CONTROL_ENABLE_REG_WRITE,
  input  logic        wb_valid,
  input  logic [2:0]  wb_reg,
  input  logic [31:0] wb_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_opA,
  output logic [31:0] out_opB,
  output logic        wb_err
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] READ = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_JALR = 3'b101;

  logic [1:0]  r_state;
  logic [31:0] r_instr;
  logic [7:0]  r_sb;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_opA;
  logic [31:0] r_out_opB;
  logic        r_wb_err;

  logic [2:0]  w_srcA;
  logic [2:0]  w_srcB;
  logic        w_hazard;
  logic        w_accept;
  logic        w_dest_en;
  logic [2:0]  w_dest;
  logic        w_sb_set;
  logic [7:0]  w_sb_nxt;
  logic        w_fwdA;
  logic        w_fwdB;
  logic [31:0] w_opA;
  logic [31:0] w_opB;
  logic        w_handoff;

  // Issue-side hazard check against the registered scoreboard only;
  // r0 is never pending, so its bit is ignored.
  assign w_srcA = in_instr[21:19];
  assign w_srcB = in_instr[18:16];

  assign w_hazard = ((w_srcA != 3'd0) & r_sb[w_srcA])
                  | ((w_srcB != 3'd0) & r_sb[w_srcB]);

  assign in_ready = (r_state == IDLE) & ~w_hazard & ~reset;
  assign w_accept = in_valid & in_ready;

  // Destination register of the instruction being issued.
  always_comb begin
    w_dest_en = 1'b0;
    w_dest    = in_instr[2:0];
    unique case (in_instr[24:22])
      OP_ADD, OP_NOR: begin
        w_dest_en = 1'b1;
        w_dest    = in_instr[2:0];
      end
      OP_LW, OP_JALR: begin
        w_dest_en = 1'b1;
        w_dest    = in_instr[18:16];
      end
      default: begin
        w_dest_en = 1'b0;
        w_dest    = in_instr[2:0];
      end
    endcase
  end

  assign w_sb_set = w_accept & w_dest_en & (w_dest != 3'd0);

  // Clear first, then set, so a same-cycle set of one bit wins.
  always_comb begin
    w_sb_nxt = r_sb;
    if (wb_valid) begin
      w_sb_nxt[wb_reg] = 1'b0;
    end
    if (w_sb_set) begin
      w_sb_nxt[w_dest] = 1'b1;
    end
  end

  // Register-file write port is a straight pass-through of the
  // writeback; it stays live even while reset is asserted.
  assign write_reg   = wb_reg;
  assign write_value = wb_value;
  assign CONTROL_ENABLE_REG_WRITE = wb_valid & (wb_reg != 3'd0);

  assign read_regA = r_instr[21:19];
  assign read_regB = r_instr[18:16];

  // A writeback landing in the READ cycle is newer than what the
  // register file returns, so it takes priority (never for r0).
  assign w_fwdA = wb_valid & (wb_reg != 3'd0)
                & (wb_reg == read_regA);
  assign w_fwdB = wb_valid & (wb_reg != 3'd0)
                & (wb_reg == read_regB);

  assign w_opA = w_fwdA ? wb_value : aluValA;
  assign w_opB = w_fwdB ? wb_value : regBvalue;

  assign w_handoff = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_instr     <= 32'd0;
      r_sb        <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_opA   <= 32'd0;
      r_out_opB   <= 32'd0;
      r_wb_err    <= 1'b0;
    end else begin
      r_sb     <= w_sb_nxt;
      r_wb_err <= wb_valid & ~r_sb[wb_reg];
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_instr <= in_instr;
            r_state <= READ;
          end
        end
        READ: begin
          r_out_instr <= r_instr;
          r_out_opA   <= w_opA;
          r_out_opB   <= w_opB;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (w_handoff) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_opA   = r_out_opA;
  assign out_opB   = r_out_opB;
  assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl: a table of single-
// instruction vectors plus directed multi-cycle sequences.
module tb_reg_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [2:0]  read_regA;
  logic [2:0]  read_regB;
  logic [31:0] aluValA;
  logic [31:0] regBvalue;
  logic [2:0]  write_reg;
  logic [31:0] write_value;
  logic        CONTROL_ENABLE_REG_WRITE;
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic [31:0] wb_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_opA;
  logic [31:0] out_opB;
  logic        wb_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rf [8];

  always #5 clk = ~clk;

  assign aluValA   = rf[read_regA];
  assign regBvalue = rf[read_regB];

  reg_access_ctrl dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .read_regA(read_regA),
    .read_regB(read_regB),
    .aluValA(aluValA),
    .regBvalue(regBvalue),
    .write_reg(write_reg),
    .write_value(write_value),
    .CONTROL_ENABLE_REG_WRITE(CONTROL_ENABLE_REG_WRITE),
    .wb_valid(wb_valid),
    .wb_reg(wb_reg),
    .wb_value(wb_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_opA(out_opA),
    .out_opB(out_opB),
    .wb_err(wb_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic        wbv;
    logic [2:0]  wbr;
    logic [31:0] wbval;
    logic [31:0] expA;
    logic [31:0] expB;
    logic        dest_en;
    logic [2:0]  dest;
  } vec_t;

  vec_t vt [7];

  function automatic logic [31:0] enc(
    input logic [2:0] op, input logic [2:0] a,
    input logic [2:0] b, input logic [2:0] d);
    return {7'd0, op, a, b, 13'd0, d};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rf[0] = 32'h0;  rf[1] = 32'h5;  rf[2] = 32'h7;  rf[3] = 32'h30;
    rf[4] = 32'h44; rf[5] = 32'h55; rf[6] = 32'h66; rf[7] = 32'h77;

    vt[0] = '{enc(3'd0,3'd1,3'd2,3'd3), 1'b0, 3'd0, 32'h0,
              32'h5, 32'h7, 1'b1, 3'd3};
    vt[1] = '{enc(3'd1,3'd4,3'd5,3'd6), 1'b1, 3'd2, 32'hDEAD,
              32'h44, 32'h55, 1'b1, 3'd6};
    vt[2] = '{enc(3'd3,3'd1,3'd2,3'd0), 1'b1, 3'd2, 32'hDEAD,
              32'h5, 32'hDEAD, 1'b0, 3'd0};
    vt[3] = '{enc(3'd2,3'd0,3'd4,3'd0), 1'b1, 3'd0, 32'hBEEF,
              32'h0, 32'h44, 1'b1, 3'd4};
    vt[4] = '{enc(3'd5,3'd6,3'd7,3'd0), 1'b1, 3'd6, 32'h1234,
              32'h1234, 32'h77, 1'b1, 3'd7};
    vt[5] = '{enc(3'd4,3'd3,3'd3,3'd0), 1'b1, 3'd3, 32'hAAAA,
              32'hAAAA, 32'hAAAA, 1'b0, 3'd0};
    vt[6] = '{enc(3'd6,3'd0,3'd0,3'd0), 1'b0, 3'd0, 32'h0,
              32'h0, 32'h0, 1'b0, 3'd0};

    reset = 1'b1;
    in_valid = 1'b1;
    in_instr = enc(3'd0, 3'd1, 3'd2, 3'd3);
    wb_valid = 1'b0;
    wb_reg = 3'd0;
    wb_value = 32'd0;
    out_ready = 1'b0;
    #1;
    chk("in_ready_in_reset", in_ready, 1'b0);
    step();
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_opA", out_opA, 32'd0);
    chk("rst_out_opB", out_opB, 32'd0);
    chk("rst_wb_err", wb_err, 1'b0);
    chk("rst_read_regA", read_regA, 3'd0);
    chk("rst_read_regB", read_regB, 3'd0);
    #1;
    chk("rst_in_ready_idle", in_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_instr = vt[i].instr;
      #1;
      chk("vec_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      wb_valid = vt[i].wbv;
      wb_reg = vt[i].wbr;
      wb_value = vt[i].wbval;
      #1;
      chk("vec_read_regA", read_regA, vt[i].instr[21:19]);
      chk("vec_read_regB", read_regB, vt[i].instr[18:16]);
      chk("vec_strobe", CONTROL_ENABLE_REG_WRITE,
          vt[i].wbv & (vt[i].wbr != 3'd0));
      chk("vec_out_valid_read", out_valid, 1'b0);
      step();
      wb_valid = 1'b0;
      chk("vec_out_valid", out_valid, 1'b1);
      chk("vec_out_instr", out_instr, vt[i].instr);
      chk("vec_out_opA", out_opA, vt[i].expA);
      chk("vec_out_opB", out_opB, vt[i].expB);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("vec_out_valid_drop", out_valid, 1'b0);
      if (vt[i].dest_en) begin
        wb_valid = 1'b1;
        wb_reg = vt[i].dest;
        wb_value = rf[vt[i].dest];
        #1;
        chk("vec_wb_write_reg", write_reg, vt[i].dest);
        step();
        wb_valid = 1'b0;
        chk("vec_dest_pending", wb_err, 1'b0);
      end
    end

    // Dependent instruction stalls until r3 is written back.
    in_valid = 1'b1;
    in_instr = enc(3'd0, 3'd1, 3'd2, 3'd3);
    step();
    in_valid = 1'b0;
    step();
    chk("dep_first_opA", out_opA, 32'h5);
    chk("dep_first_opB", out_opB, 32'h7);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = enc(3'd0, 3'd3, 3'd1, 3'd4);
    #1;
    chk("hazard_r3", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hazard_hold", in_ready, 1'b0);
    end
    wb_valid = 1'b1;
    wb_reg = 3'd3;
    wb_value = 32'd12;
    rf[3] = 32'd12;
    #1;
    chk("hazard_same_cycle", in_ready, 1'b0);
    step();
    wb_valid = 1'b0;
    #1;
    chk("hazard_released", in_ready, 1'b1);
    chk("hazard_wb_err", wb_err, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("dep_opA", out_opA, 32'd12);
    chk("dep_opB", out_opB, 32'h5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wb_valid = 1'b1;
    wb_reg = 3'd4;
    wb_value = 32'h44;
    step();
    wb_valid = 1'b0;
    chk("dep_r4_pending", wb_err, 1'b0);

    // Bundle held stable under backpressure.
    in_valid = 1'b1;
    in_instr = enc(3'd1, 3'd5, 3'd6, 3'd0);
    step();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    in_instr = enc(3'd3, 3'd1, 3'd2, 3'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_opA", out_opA, 32'h55);
      chk("hold_opB", out_opB, 32'h66);
      chk("hold_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;

    // Writebacks to non-pending registers.
    wb_valid = 1'b1;
    wb_reg = 3'd6;
    wb_value = 32'h600D;
    #1;
    chk("err6_strobe", CONTROL_ENABLE_REG_WRITE, 1'b1);
    chk("err6_write_reg", write_reg, 3'd6);
    chk("err6_write_value", write_value, 32'h600D);
    step();
    wb_valid = 1'b0;
    chk("err6_pulse", wb_err, 1'b1);
    step();
    chk("err6_pulse_end", wb_err, 1'b0);
    wb_valid = 1'b1;
    wb_reg = 3'd0;
    #1;
    chk("err0_no_strobe", CONTROL_ENABLE_REG_WRITE, 1'b0);
    step();
    wb_valid = 1'b0;
    chk("err0_pulse", wb_err, 1'b1);
    step();
    chk("err0_pulse_end", wb_err, 1'b0);

    // Reset while holding a bundle, with a writeback in the same cycle.
    in_valid = 1'b1;
    in_instr = enc(3'd0, 3'd1, 3'd2, 3'd3);
    step();
    in_valid = 1'b0;
    step();
    chk("rsthold_out_valid", out_valid, 1'b1);
    reset = 1'b1;
    wb_valid = 1'b1;
    wb_reg = 3'd5;
    wb_value = 32'h55;
    #1;
    chk("rsthold_in_ready", in_ready, 1'b0);
    chk("rsthold_strobe", CONTROL_ENABLE_REG_WRITE, 1'b1);
    step();
    reset = 1'b0;
    wb_valid = 1'b0;
    chk("rsthold_out_valid_0", out_valid, 1'b0);
    chk("rsthold_opA_0", out_opA, 32'd0);
    chk("rsthold_instr_0", out_instr, 32'd0);
    chk("rsthold_wb_err", wb_err, 1'b0);
    chk("rsthold_read_regA", read_regA, 3'd0);
    in_valid = 1'b1;
    in_instr = enc(3'd0, 3'd3, 3'd3, 3'd0);
    #1;
    chk("rsthold_sb_clear", in_ready, 1'b1);
    in_valid = 1'b0;

    // Same-cycle set and clear of r3: the set wins.
    in_valid = 1'b1;
    in_instr = enc(3'd0, 3'd1, 3'd2, 3'd3);
    wb_valid = 1'b1;
    wb_reg = 3'd3;
    wb_value = 32'h30;
    step();
    in_valid = 1'b0;
    wb_valid = 1'b0;
    chk("setwins_err", wb_err, 1'b1);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = enc(3'd0, 3'd3, 3'd1, 3'd0);
    #1;
    chk("setwins_stall", in_ready, 1'b0);
    in_valid = 1'b0;
    wb_valid = 1'b1;
    wb_reg = 3'd3;
    step();
    wb_valid = 1'b0;
    chk("setwins_clear_err", wb_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
